// File: rtl/jstk_spi_master.sv
// jstk_spi_master: byte-level SPI master (mode 0, MSB first) for the PmodJSTK.
// A start request seen in IDLE is registered and acted on at the following
// edge. The byte is then clocked out on SCLK while MISO is sampled on each
// SCLK rising edge. A programmable gap keeps BUSY high after the last falling
// edge, which gives the joystick the inter-byte recovery time it needs.
// All outputs come straight from flops, so they only ever change on rising
// CLK edges.
module jstk_spi_master #(
  parameter int HALF_CYCLES = 1,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       getByte,
  input  logic [7:0] sndData,
  input  logic       MISO,
  output logic       BUSY,
  output logic [7:0] RxData,
  output logic       MOSI,
  output logic       SCLK
);

  // Counter widths are sized so the counters just reach their terminal counts.
  localparam int HW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic          start_q, start_d;        // request seen in IDLE, acted on next edge
  logic [HW-1:0] half_cnt_q, half_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    rxdata_q, rxdata_d;
  logic          sclk_q, sclk_d;
  logic          busy_q, busy_d;
  logic          mosi_q, mosi_d;

  logic          half_done;
  logic          gap_done;

  assign half_done = (half_cnt_q == HALF_LAST);
  assign gap_done  = (gap_cnt_q == GAP_LAST);

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    half_cnt_d = half_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rxdata_d   = rxdata_q;
    sclk_d     = sclk_q;
    busy_d     = busy_q;
    mosi_d     = mosi_q;

    case (state_q)
      S_IDLE: begin
        sclk_d = 1'b0;
        busy_d = 1'b0;
        if (start_q) begin
          // The registered request launches the byte; a request that is
          // still high now is deliberately not re-armed.
          start_d    = 1'b0;
          tx_d       = sndData;
          mosi_d     = sndData[7];
          bit_cnt_d  = 3'd0;
          half_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = S_LOW;
        end else begin
          start_d = getByte;
        end
      end

      S_LOW: begin
        if (half_done) begin
          half_cnt_d = '0;
          sclk_d     = 1'b1;
          rx_d       = {rx_q[6:0], MISO};
          state_d    = S_HIGH;
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end

      S_HIGH: begin
        if (half_done) begin
          half_cnt_d = '0;
          sclk_d     = 1'b0;
          if (bit_cnt_q != 3'd7) begin
            // MOSI moves on the falling edge, a full half-period ahead of
            // the next rising edge.
            tx_d      = {tx_q[6:0], 1'b0};
            mosi_d    = tx_q[6];
            bit_cnt_d = bit_cnt_q + 3'd1;
            state_d   = S_LOW;
          end else begin
            rxdata_d  = rx_q;
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        sclk_d = 1'b0;
        if (gap_done) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        sclk_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset abandons any byte in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      half_cnt_q <= '0;
      bit_cnt_q  <= 3'd0;
      gap_cnt_q  <= '0;
      tx_q       <= 8'h00;
      rx_q       <= 8'h00;
      rxdata_q   <= 8'h00;
      sclk_q     <= 1'b0;
      busy_q     <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      half_cnt_q <= half_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rxdata_q   <= rxdata_d;
      sclk_q     <= sclk_d;
      busy_q     <= busy_d;
      mosi_q     <= mosi_d;
    end
  end

  assign BUSY   = busy_q;
  assign RxData = rxdata_q;
  assign MOSI   = mosi_q;
  assign SCLK   = sclk_q;

endmodule

// File: doc/jstk_spi_master.md
# jstk_spi_master

Byte-level SPI master (mode 0, MSB first) for the PmodJSTK joystick link. It sits directly downstream of the joystick transfer controller. That controller asserts `getByte` with a byte on `sndData`, waits for `BUSY` to rise and then fall, and reads `RxData`. This block drives `SCLK` and `MOSI`, samples `MISO`, and enforces the inter-byte gap the PmodJSTK requires. Slave select stays with the controller.

## Interface
Parameters:
- `HALF_CYCLES`, default 1: `CLK` cycles per `SCLK` half-period. `SCLK` = `CLK` / (2·`HALF_CYCLES`). Legal range ≥ 1.
- `GAP_CYCLES`, default 1: `CLK` cycles `BUSY` stays high after the last `SCLK` falling edge. At 66.67 kHz one cycle is 15 µs. Legal range ≥ 1.

Ports:
- `CLK`  in  1  system clock, 66.67 kHz; all logic on rising edge.
- `RESET`  in  1  reset, synchronous, active-high.
- `getByte`  in  1  start request; level-sensitive; sampled only in IDLE.
- `sndData`  in  8  byte to transmit; captured when a transfer starts.
- `MISO`  in  1  serial data from slave.
- `BUSY`  out  1  high while a transfer or gap is in progress.
- `RxData`  out  8  last byte received; holds between transfers.
- `MOSI`  out  1  serial data to slave.
- `SCLK`  out  1  serial clock; idles low.

## Operation
- States: IDLE, LOW, HIGH, GAP. Supporting registers: half-period counter, bit counter (0..7), 8-bit tx shift register, 8-bit rx shift register, gap counter.
- IDLE: `SCLK`=0, `BUSY`=0, `MOSI` holds its last value. If `getByte`=1, then on the next edge: load tx←`sndData`, `MOSI`←`sndData[7]`, clear bit counter, `BUSY`←1, go to LOW.
- LOW: `SCLK`=0 for `HALF_CYCLES` cycles. Then `SCLK`←1, rx←{rx[6:0], `MISO`}, go to HIGH.
- HIGH: `SCLK`=1 for `HALF_CYCLES` cycles. Then `SCLK`←0 and:
  - If bit counter < 7: shift tx left, `MOSI`←next bit, increment bit counter, go to LOW.
  - If bit counter = 7: `RxData`←rx (the 8 sampled bits, first sample in bit 7), go to GAP.
- GAP: `SCLK`=0, `BUSY`=1 for `GAP_CYCLES` cycles. Then `BUSY`←0, go to IDLE.
- `getByte` during LOW/HIGH/GAP is ignored. A held `getByte` does not queue a second transfer.
- `getByte` still high when IDLE is re-entered starts a new transfer on the next edge. The controller drops `getByte` once it sees `BUSY`, so this does not occur in normal use.
- `sndData` changes after capture do not affect the byte in flight.
- Reset values (also apply on `RESET` mid-transfer, which abandons the byte): state IDLE, `SCLK`=0, `BUSY`=0, `MOSI`=0, `RxData`=8'h00. All counters and shift registers clear.
- Reset has priority over `getByte` in the same cycle.

## Timing
All edge numbers count from edge 0, the `CLK` edge where `getByte`=1 is sampled in IDLE. H = `HALF_CYCLES`, G = `GAP_CYCLES`.
- `BUSY` rises at edge 1 and falls at edge 1+16H+G. The next start can be sampled at edge 2+16H+G.
- Bit i (i=0 is MSB): `SCLK` rises at edge 1+H+2Hi and falls at edge 1+2H(i+1).
- `MOSI` changes only at the start edge and at `SCLK` falling edges, so it is stable for a full half-period before each rising edge.
- `MISO` is sampled on the `CLK` edge that raises `SCLK`.
- `RxData` updates at edge 1+16H, at least G cycles before `BUSY` falls. The controller therefore reads a valid byte after observing `BUSY`=0.
- Defaults (H=1, G=1): `BUSY` is high on edges 1–17, `RxData` updates at edge 17, `BUSY` is low at edge 18; 8 `SCLK` pulses, each 1 cycle high.
- The controller runs on the falling edge of `CLK`. All outputs of this block change only on rising edges and are therefore stable for half a cycle before the controller samples them.

## Test plan
- Loopback (`MISO` tied to `MOSI`), `sndData`=8'hA5, 1-cycle `getByte` pulse → `MOSI` bit sequence 1,0,1,0,0,1,0,1; `RxData`=8'hA5 at edge 17; `BUSY` falls at edge 18.
- Slave model shifts out 8'h3C on `SCLK` falling edges while master sends 8'h80 → `RxData`=8'h3C; exactly 8 `SCLK` rising edges; `SCLK`=0 throughout IDLE and GAP.
- `HALF_CYCLES`=4, `GAP_CYCLES`=3, loopback 8'h5A → each `SCLK` phase is 4 cycles; `RxData`=8'h5A at edge 65; `BUSY` falls at edge 68.
- `getByte` pulsed again at edges 5 and 17 with a different `sndData` → ignored; `BUSY` stays high with no restart; only the first byte is transmitted.
- `RESET` asserted at edge 9 mid-byte → next edge: `BUSY`=0, `SCLK`=0, `MOSI`=0, `RxData`=8'h00. A subsequent transfer of 8'hC3 completes correctly.
- Five back-to-back transfers driven the way the joystick controller drives them (deassert `getByte` on `BUSY` rise, reassert after `BUSY` fall), loopback data 8'h81, 8'h00, 8'hFF, 8'h12, 8'h7E → all five received correctly; each `BUSY`-low gap is ≥ 1 cycle.
